// File: rtl/io_pad_stage.sv
// Pad-side retiming stage: sync + per-bit deglitch + edge pulses inbound, one register outbound.
// Optional feature macro: IO_PAD_EDGE_EN (core_rise/core_fall generation).
module io_pad_stage #(
    parameter int WIDTH       = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [WIDTH-1:0]     pad_in,
    output logic [WIDTH-1:0]     core_in,
    output logic [WIDTH-1:0]     core_rise,
    output logic [WIDTH-1:0]     core_fall,
    input  logic [WIDTH-1:0]     core_out,
    input  logic [WIDTH-1:0]     core_oeb,
    output logic [WIDTH-1:0]     pad_out,
    output logic [WIDTH-1:0]     pad_oeb,
    input  logic [WIDTH-1:0]     filt_en,
    input  logic [FILT_BITS-1:0] filt_len
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_core_in;
    logic [WIDTH-1:0] r_pad_out;
    logic [WIDTH-1:0] r_pad_oeb;
    logic             w_len_zero;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_len_zero = (filt_len == '0);

`ifdef IO_PAD_EDGE_EN
    logic [WIDTH-1:0] w_upd;
`endif

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        logic [FILT_BITS-1:0] r_cnt;
        logic                 r_lvl;
        logic [FILT_BITS:0]   w_neff;
        logic [FILT_BITS:0]   w_cnt_inc;
        logic                 w_diff;
        logic                 w_take;

        // Bypass (filter off or zero length) is a one-cycle filter
        assign w_neff    = (!filt_en[i] || w_len_zero)
                         ? (FILT_BITS+1)'(1)
                         : {1'b0, filt_len};
        assign w_cnt_inc = {1'b0, r_cnt} + (FILT_BITS+1)'(1);
        assign w_diff    = w_sync[i] ^ r_lvl;
        assign w_take    = w_diff && (w_cnt_inc >= w_neff);

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_lvl <= w_sync[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc[FILT_BITS-1:0];
            end
        end

        assign w_core_in[i] = r_lvl;
`ifdef IO_PAD_EDGE_EN
        assign w_upd[i] = w_take;
`endif
    end

    assign core_in = w_core_in;

`ifdef IO_PAD_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // Pulses land on the same edge that updates core_in
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_upd & w_sync;
            r_fall <= w_upd & ~w_sync;
        end
    end

    assign core_rise = r_rise;
    assign core_fall = r_fall;
`else
    assign core_rise = '0;
    assign core_fall = '0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_pad_out <= '0;
            r_pad_oeb <= '1;
        end else begin
            r_pad_out <= core_out;
            r_pad_oeb <= core_oeb;
        end
    end

    assign pad_out = r_pad_out;
    assign pad_oeb = r_pad_oeb;

endmodule

// File: tb/tb_io_pad_stage.sv
// Directed scoreboard bench for io_pad_stage; expectations queued at drive time.
// Edge-pulse expectations follow IO_PAD_EDGE_EN.
module tb_io_pad_stage;

    localparam int W  = 38;
    localparam int FB = 4;
`ifdef IO_PAD_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    localparam int CI = 0;
    localparam int RI = 1;
    localparam int FA = 2;
    localparam int PO = 3;
    localparam int PE = 4;

    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] B0   = W'(1);
    localparam logic [W-1:0] B5   = W'(1) << 5;
    localparam logic [W-1:0] V    = 38'h15_5555_5555;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  pad_in;
    logic [W-1:0]  core_in;
    logic [W-1:0]  core_rise;
    logic [W-1:0]  core_fall;
    logic [W-1:0]  core_out;
    logic [W-1:0]  core_oeb;
    logic [W-1:0]  pad_out;
    logic [W-1:0]  pad_oeb;
    logic [W-1:0]  filt_en;
    logic [FB-1:0] filt_len;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int t0;

    typedef struct {
        int           due;
        int           sig;
        logic [W-1:0] exp;
        string        tag;
    } sb_t;

    sb_t sb[$];

    io_pad_stage #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .FILT_BITS(FB)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .pad_in   (pad_in),
        .core_in  (core_in),
        .core_rise(core_rise),
        .core_fall(core_fall),
        .core_out (core_out),
        .core_oeb (core_oeb),
        .pad_out  (pad_out),
        .pad_oeb  (pad_oeb),
        .filt_en  (filt_en),
        .filt_len (filt_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges++;

    function automatic logic [W-1:0] e(input logic [W-1:0] v);
        return EDGE ? v : ZERO;
    endfunction

    function automatic logic [W-1:0] pick(input int sig);
        case (sig)
            CI:      return core_in;
            RI:      return core_rise;
            FA:      return core_fall;
            PO:      return pad_out;
            default: return pad_oeb;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sig, input int due,
                        input logic [W-1:0] v);
        sb_t it;
        it.due = due;
        it.sig = sig;
        it.exp = v;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic push_run(input string tag, input int sig, input int from,
                            input int to, input logic [W-1:0] v);
        for (int k = from; k <= to; k++) push(tag, sig, k, v);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare every queued expectation that falls due on this edge
    always @(posedge clk) begin
        #1;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due == edges) begin
                chk($sformatf("%s@%0d", sb[k].tag, sb[k].due),
                    pick(sb[k].sig), sb[k].exp);
                sb.delete(k);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pad_in   = ONES;
        core_out = ZERO;
        core_oeb = ZERO;
        filt_en  = ZERO;
        filt_len = '0;
        step(2);
        chk("t1_rst_core_in", core_in, ZERO);
        chk("t1_rst_pad_oeb", pad_oeb, ONES);
        chk("t1_rst_pad_out", pad_out, ZERO);
        chk("t1_rst_rise", core_rise, ZERO);

        t0 = edges;
        rst_n = 1'b1;
        push_run("t1_ci", CI, t0 + 1, t0 + 2, ZERO);
        push_run("t1_ci", CI, t0 + 3, t0 + 4, ONES);
        push("t1_rise", RI, t0 + 2, ZERO);
        push("t1_rise", RI, t0 + 3, e(ONES));
        push("t1_rise", RI, t0 + 4, ZERO);
        push("t1_fall", FA, t0 + 3, ZERO);
        step(5);

        t0 = edges;
        pad_in = ZERO;
        push("t1b_ci", CI, t0 + 2, ONES);
        push("t1b_ci", CI, t0 + 3, ZERO);
        push("t1b_fall", FA, t0 + 3, e(ONES));
        push("t1b_fall", FA, t0 + 4, ZERO);
        push("t1b_rise", RI, t0 + 3, ZERO);
        step(5);

        t0 = edges;
        pad_in = B5;
        push("t2_ci", CI, t0 + 2, ZERO);
        push("t2_ci", CI, t0 + 3, B5);
        push_run("t2_ci", CI, t0 + 4, t0 + 5, ZERO);
        push("t2_rise", RI, t0 + 2, ZERO);
        push("t2_rise", RI, t0 + 3, e(B5));
        push_run("t2_rise", RI, t0 + 4, t0 + 5, ZERO);
        push("t2_fall", FA, t0 + 3, ZERO);
        push("t2_fall", FA, t0 + 4, e(B5));
        push("t2_fall", FA, t0 + 5, ZERO);
        step(1);
        pad_in = ZERO;
        step(6);

        filt_en  = B0;
        filt_len = 4'd4;
        t0 = edges;
        pad_in = B0;
        push_run("t3_short_ci", CI, t0 + 1, t0 + 9, ZERO);
        push_run("t3_short_rise", RI, t0 + 1, t0 + 9, ZERO);
        step(3);
        pad_in = ZERO;
        step(7);

        t0 = edges;
        pad_in = B0;
        push("t3_long_ci", CI, t0 + 5, ZERO);
        push("t3_long_ci", CI, t0 + 6, B0);
        push("t3_long_ci", CI, t0 + 9, B0);
        push("t3_long_ci", CI, t0 + 10, ZERO);
        push("t3_long_rise", RI, t0 + 6, e(B0));
        push("t3_long_rise", RI, t0 + 7, ZERO);
        push("t3_long_fall", FA, t0 + 6, ZERO);
        push("t3_long_fall", FA, t0 + 10, e(B0));
        step(4);
        pad_in = ZERO;
        step(10);

        t0 = edges;
        pad_in = B0;
        push_run("t3_restart_ci", CI, t0 + 1, t0 + 14, ZERO);
        push_run("t3_restart_rise", RI, t0 + 1, t0 + 14, ZERO);
        step(3);
        pad_in = ZERO;
        step(1);
        pad_in = B0;
        step(3);
        pad_in = ZERO;
        step(8);

        filt_len = 4'd0;
        t0 = edges;
        pad_in = B0;
        push("t4_len0_ci", CI, t0 + 2, ZERO);
        push("t4_len0_ci", CI, t0 + 3, B0);
        step(5);
        t0 = edges;
        pad_in = ZERO;
        push("t4_len0_ci", CI, t0 + 2, B0);
        push("t4_len0_ci", CI, t0 + 3, ZERO);
        step(5);

        filt_len = 4'd15;
        t0 = edges;
        pad_in = B0;
        push("t4_len15_ci", CI, t0 + 16, ZERO);
        push("t4_len15_ci", CI, t0 + 17, B0);
        push("t4_len15_rise", RI, t0 + 16, ZERO);
        push("t4_len15_rise", RI, t0 + 17, e(B0));
        step(19);

        t0 = edges;
        pad_in = ZERO;
        push("t4_shrink_ci", CI, t0 + 7, B0);
        push("t4_shrink_ci", CI, t0 + 8, ZERO);
        push("t4_shrink_fall", FA, t0 + 8, e(B0));
        step(7);
        filt_len = 4'd2;
        step(3);

        filt_en  = ZERO;
        filt_len = 4'd0;
        t0 = edges;
        core_out = ZERO;
        core_oeb = ONES;
        push("t5_po", PO, t0 + 1, ZERO);
        push("t5_pe", PE, t0 + 1, ONES);
        step(1);
        t0 = edges;
        core_out = V;
        core_oeb = ZERO;
        #1;
        chk("t5_lat_po", pad_out, ZERO);
        push("t5_po", PO, t0 + 1, V);
        push("t5_pe", PE, t0 + 1, ZERO);
        step(1);
        t0 = edges;
        core_out = ~V;
        core_oeb = V;
        push("t5_po", PO, t0 + 1, ~V);
        push("t5_pe", PE, t0 + 1, V);
        step(2);

        t0 = edges;
        pad_in = ONES;
        push("t5_pre_ci", CI, t0 + 3, ONES);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_pad_oeb", pad_oeb, ONES);
        chk("t5_async_pad_out", pad_out, ZERO);
        chk("t5_async_core_in", core_in, ZERO);
        chk("t5_async_rise", core_rise, ZERO);
        step(2);

        t0 = edges;
        rst_n = 1'b1;
        push("t5_rel_ci", CI, t0 + 2, ZERO);
        push("t5_rel_ci", CI, t0 + 3, ONES);
        push("t5_rel_rise", RI, t0 + 2, ZERO);
        push("t5_rel_rise", RI, t0 + 3, e(ONES));
        push("t5_rel_pe", PE, t0 + 1, V);
        step(6);

        chk("sb_drain", W'(sb.size()), ZERO);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
